// File: rtl/snake_pkg.sv
// Direction encoding shared by the snake input conditioner and the snake controller.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'b00,
    DIR_LEFT  = 2'b01,
    DIR_UP    = 2'b10,
    DIR_DOWN  = 2'b11
  } dir_e;

  // Opposite directions differ only in the low bit of their code.
  function automatic dir_e oppositeDir(input dir_e d);
    return dir_e'({d[1], ~d[0]});
  endfunction

  function automatic int cntWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button: two-flop synchronizer, stable-count debouncer and a
// single-cycle press pulse on each debounced 0->1 transition.
module btn_debounce
  import snake_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 2_500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

  localparam int            CW      = cntWidth(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any cycle where the synced input agrees with the accepted level restarts the count.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    press_d = level_d & ~level_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/dir_input_conditioner.sv
// Turns four bouncing direction buttons into a filtered pending direction request,
// a committed heading and the periodic move tick for the snake controller.
module dir_input_conditioner
  import snake_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 2_500_000,
  parameter int TICK_DIV        = 12_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_u,
  input  logic       btn_d,
  input  logic       btn_l,
  input  logic       btn_r,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic       move_tick,
  output logic [1:0] heading
);

  localparam int            TW       = cntWidth(TICK_DIV);
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);

  logic [3:0]    press;
  logic          evtValid;
  dir_e          evtDir;
  dir_e          refDir;
  logic          moveTick;
  logic [TW-1:0] tickCnt_q, tickCnt_d;
  dir_e          heading_q, heading_d;
  dir_e          pendDir_q, pendDir_d;
  logic          pendValid_q, pendValid_d;
  logic [3:0]    dirOh_q, dirOh_d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uDebR (
    .clk(clk), .rst(rst), .btn_i(btn_r), .press_o(press[DIR_RIGHT]));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uDebL (
    .clk(clk), .rst(rst), .btn_i(btn_l), .press_o(press[DIR_LEFT]));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uDebU (
    .clk(clk), .rst(rst), .btn_i(btn_u), .press_o(press[DIR_UP]));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uDebD (
    .clk(clk), .rst(rst), .btn_i(btn_d), .press_o(press[DIR_DOWN]));

  always_comb begin
    evtValid = 1'b1;
    evtDir   = DIR_RIGHT;
    if      (press[DIR_RIGHT]) evtDir = DIR_RIGHT;
    else if (press[DIR_LEFT])  evtDir = DIR_LEFT;
    else if (press[DIR_UP])    evtDir = DIR_UP;
    else if (press[DIR_DOWN])  evtDir = DIR_DOWN;
    else                       evtValid = 1'b0;
  end

  assign moveTick = (tickCnt_q == TICK_MAX);

  // A press landing on a tick is judged against the heading that tick commits.
  always_comb begin
    refDir      = (moveTick && pendValid_q) ? pendDir_q : heading_q;
    heading_d   = heading_q;
    pendValid_d = pendValid_q;
    pendDir_d   = pendDir_q;
    tickCnt_d   = moveTick ? '0 : tickCnt_q + 1'b1;
    if (moveTick && pendValid_q) begin
      heading_d   = pendDir_q;
      pendValid_d = 1'b0;
    end
    if (evtValid && (evtDir != oppositeDir(refDir))) begin
      pendValid_d = 1'b1;
      pendDir_d   = evtDir;
    end
    dirOh_d = pendValid_d ? (4'b0001 << pendDir_d) : 4'b0000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tickCnt_q   <= '0;
      heading_q   <= DIR_RIGHT;
      pendDir_q   <= DIR_RIGHT;
      pendValid_q <= 1'b0;
      dirOh_q     <= 4'b0000;
    end else begin
      tickCnt_q   <= tickCnt_d;
      heading_q   <= heading_d;
      pendDir_q   <= pendDir_d;
      pendValid_q <= pendValid_d;
      dirOh_q     <= dirOh_d;
    end
  end

  assign right     = dirOh_q[DIR_RIGHT];
  assign left      = dirOh_q[DIR_LEFT];
  assign up        = dirOh_q[DIR_UP];
  assign down      = dirOh_q[DIR_DOWN];
  assign move_tick = moveTick;
  assign heading   = heading_q;

endmodule

// File: tb/tb_dir_input_conditioner.sv
// Bench for dir_input_conditioner: directed scenarios plus random button traffic,
// all compared cycle by cycle against a behavioural model of the button rules.
`timescale 1ns/1ps
module tb_dir_input_conditioner;

  localparam int DB = 4;
  localparam int TD = 8;
  localparam int HL = DB + 2;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       btnU = 1'b0;
  logic       btnD = 1'b0;
  logic       btnL = 1'b0;
  logic       btnR = 1'b0;
  logic       up, down, left, right, moveTick;
  logic [1:0] heading;

  int checks = 0;
  int passes = 0;

  // Model state; button bit index equals direction code (0 R, 1 L, 2 U, 3 D).
  int         edgeCnt;
  logic [3:0] rawHist [HL];
  logic [3:0] lvl;
  logic [3:0] pressQ;
  logic [1:0] mHeading;
  logic [1:0] mPendDir;
  logic       mPendValid;

  always #5 clk = ~clk;

  dir_input_conditioner #(.DEBOUNCE_CYCLES(DB), .TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst),
    .btn_u(btnU), .btn_d(btnD), .btn_l(btnL), .btn_r(btnR),
    .up(up), .down(down), .left(left), .right(right),
    .move_tick(moveTick), .heading(heading)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
  endtask

  function automatic logic [1:0] reverseOf(input logic [1:0] d);
    case (d)
      2'd0:    return 2'd1;
      2'd1:    return 2'd0;
      2'd2:    return 2'd3;
      default: return 2'd2;
    endcase
  endfunction

  task automatic modelReset();
    edgeCnt = 0;
    for (int i = 0; i < HL; i++) rawHist[i] = 4'b0000;
    lvl        = 4'b0000;
    pressQ     = 4'b0000;
    mHeading   = 2'd0;
    mPendDir   = 2'd0;
    mPendValid = 1'b0;
  endtask

  // A button level is accepted once DB consecutive synchronized samples disagree with it.
  task automatic modelStep();
    logic       tick;
    logic [1:0] refDir;
    logic [1:0] chosen;
    logic       found;
    logic       stable;
    logic [3:0] newPress;
    edgeCnt++;
    tick   = (edgeCnt % TD == 0);
    refDir = (tick && mPendValid) ? mPendDir : mHeading;
    if (tick && mPendValid) begin
      mHeading   = mPendDir;
      mPendValid = 1'b0;
    end
    found  = 1'b0;
    chosen = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!found && pressQ[i]) begin
        found  = 1'b1;
        chosen = 2'(i);
      end
    end
    if (found && chosen != reverseOf(refDir)) begin
      mPendValid = 1'b1;
      mPendDir   = chosen;
    end
    for (int i = HL - 1; i > 0; i--) rawHist[i] = rawHist[i-1];
    rawHist[0] = {btnD, btnU, btnL, btnR};
    newPress = 4'b0000;
    for (int b = 0; b < 4; b++) begin
      stable = 1'b1;
      for (int j = 2; j < HL; j++) if (rawHist[j][b] == lvl[b]) stable = 1'b0;
      if (stable) begin
        lvl[b]      = ~lvl[b];
        newPress[b] = lvl[b];
      end
    end
    pressQ = newPress;
  endtask

  task automatic stepCycle();
    logic [3:0] expDirs;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    expDirs = mPendValid ? (4'b0001 << mPendDir) : 4'b0000;
    checkOutput("heading", 32'(heading), 32'(mHeading));
    checkOutput("dirs", 32'({down, up, left, right}), 32'(expDirs));
    checkOutput("move_tick", 32'(moveTick), 32'(edgeCnt % TD == TD - 1));
  endtask

  task automatic applyStimulus(input logic [3:0] btns, input int n);
    {btnD, btnU, btnL, btnR} = btns;
    repeat (n) stepCycle();
  endtask

  task automatic doReset();
    #($urandom_range(1, 4));
    rst = 1'b1;
    #1;
    checkOutput("asyncRstDirs", 32'({down, up, left, right}), 32'd0);
    checkOutput("asyncRstHeading", 32'(heading), 32'd0);
    checkOutput("asyncRstTick", 32'(moveTick), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    modelReset();
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int hits;
    int c;
    modelReset();
    repeat (3) @(negedge clk);
    checkOutput("rstHeading", 32'(heading), 32'd0);
    checkOutput("rstDirs", 32'({down, up, left, right}), 32'd0);
    checkOutput("rstTick", 32'(moveTick), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Idle ticks land on cycles 7, 15, 23 after release.
    for (c = 1; c <= 24; c++) begin
      stepCycle();
      checkOutput("tickAt", 32'(moveTick), 32'(c == 7 || c == 15 || c == 23));
    end

    // Left while heading right is a reversal and must be ignored.
    applyStimulus(4'b0010, 12);
    applyStimulus(4'b0000, 10);
    checkOutput("leftRejected", 32'(left), 32'd0);
    checkOutput("headingStillRight", 32'(heading), 32'd0);

    // Clean up press: request after 7 cycles, committed on the next tick.
    {btnD, btnU, btnL, btnR} = 4'b0100;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      stepCycle();
      if (up && lat == 0) lat = i;
    end
    checkOutput("upLatency", 32'(lat), 32'd7);
    for (int i = 0; i < 2 * TD && heading != 2'd2; i++) stepCycle();
    checkOutput("upCommitted", 32'(heading), 32'd2);
    checkOutput("upCleared", 32'(up), 32'd0);
    applyStimulus(4'b0000, 10);

    // Bouncing left: no request until the level has been steady long enough.
    hits = 0;
    for (int p = 0; p < 4; p++) begin
      {btnD, btnU, btnL, btnR} = (p % 2 == 0) ? 4'b0010 : 4'b0000;
      repeat (2) begin
        stepCycle();
        if (left) hits++;
      end
    end
    checkOutput("bounceQuiet", 32'(hits), 32'd0);
    {btnD, btnU, btnL, btnR} = 4'b0010;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      stepCycle();
      if (left && lat == 0) lat = i;
    end
    checkOutput("leftLatency", 32'(lat), 32'd7);
    applyStimulus(4'b0010, 8);
    applyStimulus(4'b0000, 12);

    // Back to up, then right and up together: right wins.
    applyStimulus(4'b0100, 20);
    applyStimulus(4'b0000, 12);
    checkOutput("headingUp", 32'(heading), 32'd2);
    applyStimulus(4'b0101, 7);
    checkOutput("prioRight", 32'(right), 32'd1);
    checkOutput("prioUpDropped", 32'(up), 32'd0);
    applyStimulus(4'b0101, 16);
    applyStimulus(4'b0000, 12);

    // Pending up plus a down press landing on the committing tick.
    for (int g = 0; g < TD && (edgeCnt % TD) != 1; g++) stepCycle();
    applyStimulus(4'b0100, 8);
    applyStimulus(4'b1100, 6);
    checkOutput("pendUp", 32'(up), 32'd1);
    stepCycle();
    checkOutput("tickHeadingUp", 32'(heading), 32'd2);
    checkOutput("downRejected", 32'(down), 32'd0);
    checkOutput("pendCleared", 32'(up), 32'd0);
    applyStimulus(4'b1100, 8);
    checkOutput("stillUp", 32'(heading), 32'd2);
    applyStimulus(4'b0000, 10);

    // Random traffic with occasional mid-run resets.
    for (int s = 0; s < 250; s++) begin
      if ($urandom_range(0, 39) == 0) doReset();
      applyStimulus(4'($urandom_range(0, 15)), $urandom_range(1, 12));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
